// File: rtl/t0_pkg.sv
// Shared types for the ESU axis scheduler: default axis count, axis index type
// and the sequencer state encoding.
package t0_pkg;

  localparam int NUM_AXES_DEFAULT = 3;
  localparam int AXIS_W_DEFAULT   = 2;

  typedef logic [AXIS_W_DEFAULT-1:0] axis_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/lowest_set_picker.sv
// Combinational priority picker: reports whether any mask bit is set and the
// index of the lowest set bit.
module lowest_set_picker import t0_pkg::*; #(
  parameter int NUM_AXES = NUM_AXES_DEFAULT,
  parameter int AXIS_W   = AXIS_W_DEFAULT
) (
  input  logic [NUM_AXES-1:0] i_mask,
  output logic                o_found,
  output logic [AXIS_W-1:0]   o_idx
);

  always_comb begin
    o_found = |i_mask;
    o_idx   = '0;
    // Scan downward so the last assignment wins with the lowest index.
    for (int i = NUM_AXES - 1; i >= 0; i--) begin
      if (i_mask[i]) o_idx = AXIS_W'(i);
    end
  end

endmodule

// File: rtl/esu_scheduler.sv
// Sequences the shared ESU over dirty axes after each update strobe.
// Optional ESU watchdog enabled by defining T0_ESU_WATCHDOG_EN.
//
// state | meaning
// IDLE  | no sweep; waiting for update
// SCAN  | pick lowest dirty axis, or end sweep when none left
// START | one-cycle esu_start for the latched axis
// WAIT  | hold axis until esu_done (or watchdog timeout)
module esu_scheduler import t0_pkg::*; #(
  parameter int NUM_AXES   = NUM_AXES_DEFAULT,
  parameter int AXIS_W     = AXIS_W_DEFAULT,
  parameter int WDT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              update,
  input  logic              cl_we,
  input  logic [AXIS_W-1:0] cl_wa,
  input  logic              force_all,
  input  logic              esu_done,
  output logic              esu_start,
  output logic [AXIS_W-1:0] axis,
  output logic              busy,
  output logic              sweep_done,
  output logic              overrun,
  output logic              wdt_fault
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_SCAN  = 2'(SCAN);
  localparam logic [1:0] ST_START = 2'(START);
  localparam logic [1:0] ST_WAIT  = 2'(WAIT);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [NUM_AXES-1:0] r_pending;
  logic [NUM_AXES-1:0] r_work;
  logic [NUM_AXES-1:0] w_set;
  logic [NUM_AXES-1:0] w_clr;
  logic [NUM_AXES-1:0] w_work_nxt;
  logic [NUM_AXES-1:0] w_pending_nxt;
  logic [AXIS_W-1:0]   r_axis;
  logic [AXIS_W-1:0]   w_pick;
  logic                w_found;
  logic                w_timeout;
  logic                w_wait_end;
  logic                r_overrun;

  lowest_set_picker #(
    .NUM_AXES (NUM_AXES),
    .AXIS_W   (AXIS_W)
  ) u_picker (
    .i_mask  (r_work),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  // Writes beyond NUM_AXES match no bit and are dropped.
  always_comb begin
    w_set = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      if (force_all || (cl_we && (cl_wa == AXIS_W'(i)))) w_set[i] = 1'b1;
    end
  end

  assign w_wait_end = (r_state == ST_WAIT) && (esu_done || w_timeout);

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      if (w_wait_end && (r_axis == AXIS_W'(i))) w_clr[i] = 1'b1;
    end
  end

  // Clear before merge so an update coincident with esu_done re-dirties the axis.
  assign w_work_nxt    = (r_work & ~w_clr) | (update ? (r_pending | w_set) : '0);
  assign w_pending_nxt = update ? '0 : (r_pending | w_set);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (update) w_state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (w_found)     w_state_nxt = ST_START;
        else if (update) w_state_nxt = ST_SCAN;
        else             w_state_nxt = ST_IDLE;
      end
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_wait_end) w_state_nxt = ST_SCAN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pending <= '1;
      r_work    <= '0;
      r_axis    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_work    <= w_work_nxt;
      if ((r_state == ST_SCAN) && w_found) r_axis <= w_pick;
      if (update && (r_state != ST_IDLE)) r_overrun <= 1'b1;
    end
  end

`ifdef T0_ESU_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] r_wdt_cnt;
  logic             r_wdt_fault;

  // WAIT is only entered from START, so loading there restarts the count per op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdt_cnt   <= '0;
      r_wdt_fault <= 1'b0;
    end else begin
      if (r_state == ST_START)
        r_wdt_cnt <= WDT_W'(WDT_CYCLES - 1);
      else if ((r_state == ST_WAIT) && (r_wdt_cnt != '0))
        r_wdt_cnt <= r_wdt_cnt - 1'b1;
      if (w_timeout) r_wdt_fault <= 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_WAIT) && !esu_done && (r_wdt_cnt == '0);
  assign wdt_fault = r_wdt_fault;
`else
  assign w_timeout = 1'b0;
  assign wdt_fault = 1'b0;
`endif

  assign esu_start  = (r_state == ST_START);
  assign busy       = (r_state != ST_IDLE);
  assign sweep_done = (r_state == ST_SCAN) && !w_found;
  assign axis       = r_axis;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_esu_scheduler.sv
// Directed bench for esu_scheduler: expected axis order is queued when stimulus
// is driven and checked on every esu_start.
module tb_esu_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       update, cl_we, force_all, esu_done;
  logic [1:0] cl_wa;
  logic       esu_start, busy, sweep_done, overrun, wdt_fault;
  logic [1:0] axis;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int sd_count = 0;
  int exp_sd   = 0;
  int tu, ts, td, ts2;
  logic [1:0] exp_q[$];
  logic [1:0] e;

  esu_scheduler #(
    .NUM_AXES   (3),
    .AXIS_W     (2),
    .WDT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .update     (update),
    .cl_we      (cl_we),
    .cl_wa      (cl_wa),
    .force_all  (force_all),
    .esu_done   (esu_done),
    .esu_start  (esu_start),
    .axis       (axis),
    .busy       (busy),
    .sweep_done (sweep_done),
    .overrun    (overrun),
    .wdt_fault  (wdt_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  // Scoreboard: every start must match the next queued axis.
  always @(negedge clk) begin
    if (sweep_done === 1'b1) sd_count++;
    if (esu_start === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_start observed_axis=%0d expected=no_start", axis);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (axis === e) else begin
          failures++;
          $error("FAIL start_axis observed=%0d expected=%0d", axis, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int t);
    t = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (esu_start === 1'b1) begin
        t = edge_cnt;
        break;
      end
    end
    chk("start_timeout", 32'(t >= 0), 32'd1);
  endtask

  // Called at the negedge of the START interval; returns in the SCAN interval.
  task automatic do_done(input int delay, output int t);
    step();
    repeat (delay) step();
    esu_done = 1'b1;
    t = edge_cnt;
    step();
    esu_done = 1'b0;
  endtask

  task automatic expect_sweep_end();
    @(negedge clk);
    chk("sweep_done_pulse", 32'(sweep_done), 32'd1);
    chk("busy_in_final_scan", 32'(busy), 32'd1);
    exp_sd++;
    step();
    @(negedge clk);
    chk("sweep_done_clear", 32'(sweep_done), 32'd0);
    chk("busy_after_sweep", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; update = 1'b0; cl_we = 1'b0; cl_wa = 2'd0;
    force_all = 1'b0; esu_done = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_esu_start", 32'(esu_start), 32'd0);
    chk("rst_axis", 32'(axis), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_wdt_fault", 32'(wdt_fault), 32'd0);
    step();
    reset = 1'b0;

    // esu_done outside WAIT has no effect
    step(); esu_done = 1'b1; step(); esu_done = 1'b0;
    @(negedge clk);
    chk("stray_done_busy", 32'(busy), 32'd0);

    // First sweep solves every axis in ascending order
    step(); update = 1'b1; tu = edge_cnt;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    step(); update = 1'b0;
    wait_start(ts);
    chk("lat_update_start", 32'(ts - tu), 32'd2);
    do_done(1, td);
    wait_start(ts);
    chk("lat_done_start_a1", 32'(ts - td), 32'd2);
    do_done(0, td);
    wait_start(ts);
    chk("lat_done_start_a2", 32'(ts - td), 32'd2);
    do_done(2, td);
    expect_sweep_end();

    // Single dirty axis
    step(); cl_we = 1'b1; cl_wa = 2'd1;
    step(); cl_we = 1'b0; update = 1'b1; tu = edge_cnt;
    exp_q.push_back(2'd1);
    step(); update = 1'b0;
    wait_start(ts);
    chk("lat_single_axis", 32'(ts - tu), 32'd2);
    do_done(1, td);
    expect_sweep_end();

    // Empty sweep, then out-of-range write is ignored
    step(); update = 1'b1;
    step(); update = 1'b0;
    @(negedge clk);
    chk("empty_sweep_done", 32'(sweep_done), 32'd1);
    chk("empty_busy", 32'(busy), 32'd1);
    chk("empty_no_start", 32'(esu_start), 32'd0);
    exp_sd++;
    step(); @(negedge clk);
    chk("empty_busy_drop", 32'(busy), 32'd0);
    step(); cl_we = 1'b1; cl_wa = 2'd3;
    step(); cl_we = 1'b0; update = 1'b1;
    step(); update = 1'b0;
    @(negedge clk);
    chk("oob_sweep_done", 32'(sweep_done), 32'd1);
    exp_sd++;
    step(); @(negedge clk);
    chk("oob_busy_drop", 32'(busy), 32'd0);
    chk("no_overrun_yet", 32'(overrun), 32'd0);

    // Update during WAIT extends the sweep and sets overrun
    step(); cl_we = 1'b1; cl_wa = 2'd0; update = 1'b1;
    exp_q.push_back(2'd0);
    step(); cl_we = 1'b0; update = 1'b0;
    wait_start(ts);
    step();
    cl_we = 1'b1; cl_wa = 2'd2; update = 1'b1;
    exp_q.push_back(2'd2);
    step(); cl_we = 1'b0; update = 1'b0;
    @(negedge clk);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("axis_held_wait", 32'(axis), 32'd0);
    step(); esu_done = 1'b1; td = edge_cnt;
    step(); esu_done = 1'b0;
    wait_start(ts);
    chk("lat_extended", 32'(ts - td), 32'd2);
    do_done(0, td);
    expect_sweep_end();
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Done coincident with update re-dirtying current axis
    step(); cl_we = 1'b1; cl_wa = 2'd1; update = 1'b1;
    exp_q.push_back(2'd1);
    step(); cl_we = 1'b0; update = 1'b0;
    wait_start(ts);
    step(); step();
    esu_done = 1'b1; update = 1'b1; force_all = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    step(); esu_done = 1'b0; update = 1'b0; force_all = 1'b0;
    wait_start(ts); do_done(0, td);
    wait_start(ts); do_done(1, td);
    wait_start(ts); do_done(0, td);
    expect_sweep_end();

    // Async reset mid-WAIT
    step(); cl_we = 1'b1; cl_wa = 2'd2; update = 1'b1;
    exp_q.push_back(2'd2);
    step(); cl_we = 1'b0; update = 1'b0;
    wait_start(ts);
    step();
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_esu_start", 32'(esu_start), 32'd0);
    chk("midrst_axis", 32'(axis), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    step(); step();
    reset = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Pending is all ones after reset
    step(); update = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    step(); update = 1'b0;
    wait_start(ts); do_done(0, td);
    wait_start(ts); do_done(0, td);
    wait_start(ts); do_done(0, td);
    expect_sweep_end();

`ifdef T0_ESU_WATCHDOG_EN
    step(); force_all = 1'b1; update = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    step(); force_all = 1'b0; update = 1'b0;
    wait_start(ts); do_done(0, td);
    wait_start(ts);
    repeat (16) step();
    @(negedge clk);
    chk("wdt_not_yet", 32'(wdt_fault), 32'd0);
    step(); @(negedge clk);
    chk("wdt_fault_set", 32'(wdt_fault), 32'd1);
    wait_start(ts2);
    chk("wdt_next_start", 32'(ts2 - ts), 32'd18);
    do_done(0, td);
    expect_sweep_end();
`else
    chk("wdt_tied_low", 32'(wdt_fault), 32'd0);
`endif

    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("sweep_done_count", 32'(sd_count), 32'(exp_sd));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
